// File: rtl/sgpr_pkg.sv
// Shared definitions for the scalar register file access controller:
// address width, read-only SGPR ranges, control FSM states and the RO test.
package sgpr_pkg;

    localparam int ADDR_W = 8;

    // Read-only SGPRs: VCC-style single entry plus two hardware ranges
    localparam logic [ADDR_W-1:0] RO_VCC = 8'h7D;
    localparam logic [ADDR_W-1:0] RO_LO0 = 8'h80;
    localparam logic [ADDR_W-1:0] RO_HI0 = 8'hE8;
    localparam logic [ADDR_W-1:0] RO_LO1 = 8'hF0;
    localparam logic [ADDR_W-1:0] RO_HI1 = 8'hF8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OPND = 2'd2
    } sgpr_state_t;

    function automatic logic is_ro(input logic [ADDR_W-1:0] addr);
        return (addr == RO_VCC) ||
               ((addr >= RO_LO0) && (addr <= RO_HI0)) ||
               ((addr >= RO_LO1) && (addr <= RO_HI1));
    endfunction

endpackage

// File: rtl/sgpr_wb_rr_arb.sv
// Round-robin arbiter for the write-back requesters. The search starts at
// the rr pointer; the pointer moves just past the winner on each grant.
module sgpr_wb_rr_arb #(
    parameter int NUM_WR = 2,
    parameter int PTR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_WR-1:0] req,
    output logic [NUM_WR-1:0] gnt,
    output logic              gnt_vld,
    output logic [PTR_W-1:0]  gnt_idx
);

    logic [PTR_W-1:0] rr_ptr;
    int               idx;

    // Pick the first requester at or after the rr pointer (one-hot grant)
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_WR; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_WR;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_vld  = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

    // Advance the rr pointer past the granted requester
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % NUM_WR);
        end
    end

endmodule

// File: rtl/sgpr_access_ctrl.sv
// Scalar register file access sequencer: busy scoreboard with RAW/WAW stall,
// operand-fetch FSM driving the read ports, and a round-robin write-back port
// that drops writes to read-only SGPRs.
module sgpr_access_ctrl #(
    parameter int NUM_WR = 2,
    parameter int ADDR_W = sgpr_pkg::ADDR_W,
    parameter int DATA_W = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [ADDR_W-1:0]        iss_s0,
    input  logic [ADDR_W-1:0]        iss_s1,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic                     iss_dst64,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [ADDR_W-1:0]        rf_s0,
    output logic [ADDR_W-1:0]        rf_s1,
    input  logic [NUM_WR-1:0]        wb_valid,
    output logic [NUM_WR-1:0]        wb_ready,
    input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
    input  logic [NUM_WR*DATA_W-1:0] wb_data,
    input  logic [NUM_WR-1:0]        wb_64,
    output logic [ADDR_W-1:0]        rf_w0,
    output logic [DATA_W-1:0]        rf_wv,
    output logic                     rf_en_w,
    output logic                     rf_en_64,
    output logic                     wb_ro_err
);

    import sgpr_pkg::*;

    localparam int NREG  = 2 ** ADDR_W;
    localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    sgpr_state_t       state_q, state_d;
    logic [NREG-1:0]   busy_q, set_mask, clr_mask;
    logic [ADDR_W-1:0] s0_n, s1_n, dst_n;
    logic              hazard;

    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] g_addr, g_addr_n;
    logic [DATA_W-1:0] g_data;
    logic              g_64, g_ro;

    // Pair partners wrap modulo the register file size
    assign s0_n  = iss_s0 + ADDR_W'(1);
    assign s1_n  = iss_s1 + ADDR_W'(1);
    assign dst_n = iss_dst + ADDR_W'(1);

    // Reads always cover the full pair since the regFile returns 64 bits
    assign hazard = busy_q[iss_s0] | busy_q[s0_n] | busy_q[iss_s1] | busy_q[s1_n] |
                    busy_q[iss_dst] | (iss_dst64 & busy_q[dst_n]);

    sgpr_wb_rr_arb #(
        .NUM_WR (NUM_WR),
        .PTR_W  (PTR_W)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (wb_valid),
        .gnt     (wb_ready),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign g_addr   = wb_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign g_data   = wb_data[int'(gnt_idx)*DATA_W +: DATA_W];
    assign g_64     = wb_64[gnt_idx];
    assign g_addr_n = g_addr + ADDR_W'(1);
    assign g_ro     = is_ro(g_addr) | (g_64 & is_ro(g_addr_n));

    // Operand-fetch FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        iss_ready = 1'b0;
        op_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                iss_ready = iss_valid & ~hazard;
                if (iss_ready) state_d = READ;
            end
            READ: state_d = OPND;
            OPND: begin
                op_valid = 1'b1;
                if (op_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Scoreboard set (accepted issue) and clear (granted write) masks
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_ready && !is_ro(iss_dst)) begin
            set_mask[iss_dst] = 1'b1;
            if (iss_dst64) set_mask[dst_n] = 1'b1;
        end
        if (gnt_vld) begin
            clr_mask[g_addr] = 1'b1;
            if (g_64) clr_mask[g_addr_n] = 1'b1;
        end
    end

    // Busy scoreboard; a same-cycle set overrides a clear
    always_ff @(posedge clock) begin
        if (reset) busy_q <= '0;
        else       busy_q <= (busy_q & ~clr_mask) | set_mask;
    end

    // Read addresses latched on issue and held through OPND
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_s0 <= '0;
            rf_s1 <= '0;
        end else if (iss_ready) begin
            rf_s0 <= iss_s0;
            rf_s1 <= iss_s1;
        end
    end

    // Registered write port; read-only targets are suppressed and flagged
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_w0     <= '0;
            rf_wv     <= '0;
            rf_en_w   <= 1'b0;
            rf_en_64  <= 1'b0;
            wb_ro_err <= 1'b0;
        end else if (gnt_vld) begin
            rf_w0     <= g_addr;
            rf_wv     <= g_data;
            rf_en_w   <= ~g_ro;
            rf_en_64  <= g_64;
            wb_ro_err <= g_ro;
        end else begin
            rf_en_w   <= 1'b0;
            rf_en_64  <= 1'b0;
            wb_ro_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sgpr_access_ctrl.sv
// Directed bench for sgpr_access_ctrl with hand-computed expectations.
module tb_sgpr_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        iss_valid, iss_ready;
    logic [7:0]  iss_s0, iss_s1, iss_dst;
    logic        iss_dst64;
    logic        op_valid, op_ready;
    logic [7:0]  rf_s0, rf_s1;
    logic [1:0]  wb_valid, wb_ready;
    logic [15:0] wb_addr;
    logic [127:0] wb_data;
    logic [1:0]  wb_64;
    logic [7:0]  rf_w0;
    logic [63:0] rf_wv;
    logic        rf_en_w, rf_en_64, wb_ro_err;

    int total = 0;
    int bad   = 0;

    sgpr_access_ctrl #(.NUM_WR(2), .ADDR_W(8), .DATA_W(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_s0    (iss_s0),
        .iss_s1    (iss_s1),
        .iss_dst   (iss_dst),
        .iss_dst64 (iss_dst64),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .rf_s0     (rf_s0),
        .rf_s1     (rf_s1),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_64     (wb_64),
        .rf_w0     (rf_w0),
        .rf_wv     (rf_wv),
        .rf_en_w   (rf_en_w),
        .rf_en_64  (rf_en_64),
        .wb_ro_err (wb_ro_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; iss_valid = 1'b0; iss_s0 = '0; iss_s1 = '0; iss_dst = '0;
        iss_dst64 = 1'b0; op_ready = 1'b0; wb_valid = '0; wb_addr = '0;
        wb_data = '0; wb_64 = '0;
        tick(); tick();
        check("rst_iss_ready", 64'(iss_ready), 64'd0);
        check("rst_op_valid", 64'(op_valid), 64'd0);
        check("rst_wb_ready", 64'(wb_ready), 64'd0);
        check("rst_en_w", 64'(rf_en_w), 64'd0);
        check("rst_rf_s0", 64'(rf_s0), 64'd0);
        check("rst_rf_wv", rf_wv, 64'd0);
        check("rst_sb", 64'(|dut.busy_q), 64'd0);
        reset = 1'b0;
        tick();

        // 1: both requesters valid -> 01 then 10
        wb_valid = 2'b11;
        wb_addr  = {8'h06, 8'h05};
        wb_data  = {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        #1;
        check("t1_gnt0", 64'(wb_ready), 64'h1);
        tick();
        check("t1_en_w0", 64'(rf_en_w), 64'd1);
        check("t1_w0_a", 64'(rf_w0), 64'h05);
        check("t1_wv_a", rf_wv, 64'hAAAA_0000_0000_0001);
        check("t1_gnt1", 64'(wb_ready), 64'h2);
        tick();
        wb_valid = 2'b00;
        #1;
        check("t1_en_w1", 64'(rf_en_w), 64'd1);
        check("t1_w0_b", 64'(rf_w0), 64'h06);
        check("t1_wv_b", rf_wv, 64'hBBBB_0000_0000_0002);
        tick();
        check("t1_en_w_off", 64'(rf_en_w), 64'd0);

        // 2: issue with 64-bit destination
        iss_valid = 1'b1; iss_s0 = 8'h10; iss_s1 = 8'h12; iss_dst = 8'h20; iss_dst64 = 1'b1;
        #1;
        check("t2_iss_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check("t2_busy20", 64'(dut.busy_q[8'h20]), 64'd1);
        check("t2_busy21", 64'(dut.busy_q[8'h21]), 64'd1);
        check("t2_rf_s0", 64'(rf_s0), 64'h10);
        check("t2_rf_s1", 64'(rf_s1), 64'h12);
        check("t2_opv_read", 64'(op_valid), 64'd0);
        tick();
        check("t2_opv_rise", 64'(op_valid), 64'd1);
        tick();
        check("t2_opv_hold", 64'(op_valid), 64'd1);
        check("t2_s0_hold", 64'(rf_s0), 64'h10);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        #1;
        check("t2_opv_fall", 64'(op_valid), 64'd0);

        // 3: RAW stall on busy[0x21], released the cycle after the SMEM write grant
        iss_valid = 1'b1; iss_s0 = 8'h21; iss_s1 = 8'h30; iss_dst = 8'h40; iss_dst64 = 1'b0;
        wb_valid = 2'b10; wb_addr = {8'h20, 8'h00}; wb_64 = 2'b10;
        #1;
        check("t3_stall", 64'(iss_ready), 64'd0);
        check("t3_gnt_smem", 64'(wb_ready), 64'h2);
        tick();
        wb_valid = 2'b00; wb_64 = 2'b00;
        #1;
        check("t3_release", 64'(iss_ready), 64'd1);
        check("t3_en_w", 64'(rf_en_w), 64'd1);
        check("t3_en_64", 64'(rf_en_64), 64'd1);
        check("t3_w0", 64'(rf_w0), 64'h20);
        tick();
        iss_valid = 1'b0;
        #1;
        check("t3_busy40", 64'(dut.busy_q[8'h40]), 64'd1);
        tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // 4: writes into the read-only set are dropped and flagged
        wb_valid = 2'b01; wb_addr = {8'h00, 8'h80}; wb_64 = 2'b00;
        #1;
        check("t4_gnt_salu", 64'(wb_ready), 64'h1);
        tick();
        wb_addr = {8'h00, 8'h7D};
        #1;
        check("t4_ro80_en", 64'(rf_en_w), 64'd0);
        check("t4_ro80_err", 64'(wb_ro_err), 64'd1);
        tick();
        wb_addr = {8'h00, 8'hE9};
        #1;
        check("t4_ro7d_en", 64'(rf_en_w), 64'd0);
        check("t4_ro7d_err", 64'(wb_ro_err), 64'd1);
        tick();
        wb_addr = {8'h00, 8'h7C}; wb_64 = 2'b01;
        #1;
        check("t4_e9_en", 64'(rf_en_w), 64'd1);
        check("t4_e9_err", 64'(wb_ro_err), 64'd0);
        tick();
        wb_valid = 2'b00; wb_64 = 2'b00;
        #1;
        check("t4_pair7c_en", 64'(rf_en_w), 64'd0);
        check("t4_pair7c_err", 64'(wb_ro_err), 64'd1);
        tick();
        check("t4_err_pulse", 64'(wb_ro_err), 64'd0);

        // 4b: wrap-around pair at 0xFF/0x00
        iss_valid = 1'b1; iss_s0 = 8'h01; iss_s1 = 8'h02; iss_dst = 8'hFF; iss_dst64 = 1'b1;
        #1;
        check("t4_iss_ff", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check("t4_busyff", 64'(dut.busy_q[8'hFF]), 64'd1);
        check("t4_busy00", 64'(dut.busy_q[8'h00]), 64'd1);
        tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        iss_valid = 1'b1; iss_s0 = 8'h30; iss_s1 = 8'hFE; iss_dst = 8'h31; iss_dst64 = 1'b0;
        #1;
        check("t4_stall_wrap", 64'(iss_ready), 64'd0);
        iss_valid = 1'b0;
        wb_valid = 2'b01; wb_addr = {8'h00, 8'hFF}; wb_64 = 2'b01;
        tick();
        wb_valid = 2'b00; wb_64 = 2'b00;
        #1;
        check("t4_clrff", 64'(dut.busy_q[8'hFF]), 64'd0);
        check("t4_clr00", 64'(dut.busy_q[8'h00]), 64'd0);
        check("t4_ff_en_w", 64'(rf_en_w), 64'd1);

        // 5: reset while in OPND with busy bits set
        iss_valid = 1'b1; iss_s0 = 8'h60; iss_s1 = 8'h62; iss_dst = 8'h50; iss_dst64 = 1'b1;
        tick();
        iss_valid = 1'b0;
        tick();
        check("t5_opnd", 64'(op_valid), 64'd1);
        check("t5_busy51", 64'(dut.busy_q[8'h51]), 64'd1);
        reset = 1'b1;
        tick();
        check("t5_rst_opv", 64'(op_valid), 64'd0);
        check("t5_rst_sb", 64'(|dut.busy_q), 64'd0);
        check("t5_rst_s0", 64'(rf_s0), 64'd0);
        reset = 1'b0;
        iss_valid = 1'b1; iss_s0 = 8'h40; iss_s1 = 8'h50; iss_dst = 8'h50; iss_dst64 = 1'b1;
        #1;
        check("t5_post_iss", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
